// File: rtl/serial_cmp_pkg.sv
// Shared types for the bit-serial compare sequencer: FSM states, comparator
// states and the one-hot result struct.
package serial_cmp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } seq_state_e;

  typedef enum logic [1:0] {
    CMP_EQ,
    CMP_LESS,
    CMP_GREATER
  } cmp_state_e;

  typedef struct packed {
    logic less;
    logic eq;
    logic greater;
  } cmp_result_t;

  function automatic cmp_result_t cmp_to_result(input cmp_state_e s);
    cmp_result_t r;
    r.less    = (s == CMP_LESS);
    r.eq      = (s == CMP_EQ);
    r.greater = (s == CMP_GREATER);
    return r;
  endfunction

endpackage

// File: rtl/serial_msb_compare_core.sv
// MSB-first bit-serial magnitude comparator; the first differing bit pair
// decides the outcome, which then stays sticky until cleared.
module serial_msb_compare_core
  import serial_cmp_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       en,
  input  logic       a,
  input  logic       b,
  output cmp_state_e cmp_state
);

  cmp_state_e cmp_q, cmp_d;

  always_comb begin
    cmp_d = cmp_q;
    if (clear) begin
      cmp_d = CMP_EQ;
    end else if (en && (cmp_q == CMP_EQ) && (a != b)) begin
      cmp_d = a ? CMP_GREATER : CMP_LESS;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cmp_q <= CMP_EQ;
    end else begin
      cmp_q <= cmp_d;
    end
  end

  assign cmp_state = cmp_q;

endmodule

// File: rtl/serial_compare_sequencer.sv
// Request/response wrapper that shifts two operands MSB-first through one
// serial comparator core and holds the result until the consumer takes it.
module serial_compare_sequencer
  import serial_cmp_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int EARLY_EXIT = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_a,
  input  logic [WIDTH-1:0]           in_b,
  input  logic                       in_signed,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_less,
  output logic                       out_eq,
  output logic                       out_greater,
  output logic [$clog2(WIDTH+1)-1:0] out_bits
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  seq_state_e        state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              accept, shift_en, bit_diff, done;
  cmp_state_e        cmp_state;
  cmp_result_t       res;

  assign bit_diff = a_q[WIDTH-1] ^ b_q[WIDTH-1];

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    accept   = 1'b0;
    shift_en = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          accept  = 1'b1;
          // Flipping both sign bits maps two's-complement order onto unsigned order.
          a_d     = {in_a[WIDTH-1] ^ in_signed, in_a[WIDTH-2:0]};
          b_d     = {in_b[WIDTH-1] ^ in_signed, in_b[WIDTH-2:0]};
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        shift_en = 1'b1;
        a_d      = {a_q[WIDTH-2:0], 1'b0};
        b_d      = {b_q[WIDTH-2:0], 1'b0};
        cnt_d    = cnt_q + 1'b1;
        if ((cnt_q == LAST_BIT) || ((EARLY_EXIT != 0) && bit_diff)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
    end
  end

  serial_msb_compare_core u_core (
    .clk       (clk),
    .rst       (rst),
    .clear     (accept),
    .en        (shift_en),
    .a         (a_q[WIDTH-1]),
    .b         (b_q[WIDTH-1]),
    .cmp_state (cmp_state)
  );

  assign res         = cmp_to_result(cmp_state);
  assign done        = (state_q == ST_DONE);
  assign in_ready    = (state_q == ST_IDLE);
  assign out_valid   = done;
  assign out_less    = done & res.less;
  assign out_eq      = done & res.eq;
  assign out_greater = done & res.greater;
  assign out_bits    = done ? cnt_q : '0;

endmodule

// File: tb/tb_serial_compare_sequencer.sv
// Self-checking bench: two sequencers (early exit on / off) driven with
// directed and random requests, checked against an arithmetic reference.
module tb_serial_compare_sequencer;

  localparam int W = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       iv   [2];
  logic       irdy [2];
  logic [7:0] av   [2];
  logic [7:0] bv   [2];
  logic       sg   [2];
  logic       ov   [2];
  logic       ordy [2];
  logic       lt   [2];
  logic       eq   [2];
  logic       gt   [2];
  logic [3:0] nb   [2];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  serial_compare_sequencer #(.WIDTH(W), .EARLY_EXIT(1)) dut_ee (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(irdy[0]),
    .in_a(av[0]), .in_b(bv[0]), .in_signed(sg[0]), .out_valid(ov[0]),
    .out_ready(ordy[0]), .out_less(lt[0]), .out_eq(eq[0]),
    .out_greater(gt[0]), .out_bits(nb[0])
  );

  serial_compare_sequencer #(.WIDTH(W), .EARLY_EXIT(0)) dut_full (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(irdy[1]),
    .in_a(av[1]), .in_b(bv[1]), .in_signed(sg[1]), .out_valid(ov[1]),
    .out_ready(ordy[1]), .out_less(lt[1]), .out_eq(eq[1]),
    .out_greater(gt[1]), .out_bits(nb[1])
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: relation from plain integer compare, bit count from the
  // position of the most significant differing bit.
  function automatic void model(input int ee, input logic [7:0] a, input logic [7:0] b,
                                input logic s, output int rel, output int k);
    int ia, ib;
    if (s) begin
      ia = int'($signed(a));
      ib = int'($signed(b));
    end else begin
      ia = int'(a);
      ib = int'(b);
    end
    rel = (ia < ib) ? -1 : ((ia > ib) ? 1 : 0);
    k = W;
    if (ee != 0 && a != b) begin
      for (int i = 0; i < W; i++) if (a[i] != b[i]) k = W - i;
    end
  endfunction

  task automatic do_op(input int d, input logic [7:0] a, input logic [7:0] b,
                       input logic s, input int hold, input string tag);
    int rel, k, lat;
    logic l0, e0, g0;
    logic [3:0] n0;
    model(d == 0 ? 1 : 0, a, b, s, rel, k);
    @(negedge clk);
    av[d] = a; bv[d] = b; sg[d] = s; iv[d] = 1'b1; ordy[d] = 1'b0;
    chk({tag, ".in_ready_idle"}, int'(irdy[d]), 1);
    @(posedge clk); #1;
    iv[d] = (hold > 0) ? 1'b1 : 1'b0;
    av[d] = ~a; bv[d] = b + 8'd3;
    lat = 0;
    while (!ov[d] && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, ".latency"}, lat, k);
    chk({tag, ".less"},    int'(lt[d]), int'(rel < 0));
    chk({tag, ".eq"},      int'(eq[d]), int'(rel == 0));
    chk({tag, ".greater"}, int'(gt[d]), int'(rel > 0));
    chk({tag, ".bits"},    int'(nb[d]), k);
    l0 = lt[d]; e0 = eq[d]; g0 = gt[d]; n0 = nb[d];
    for (int i = 0; i < hold; i++) begin
      chk({tag, ".hold_in_ready"}, int'(irdy[d]), 0);
      @(posedge clk); #1;
      chk({tag, ".hold_valid"}, int'(ov[d]), 1);
      chk({tag, ".hold_flags"}, int'({lt[d], eq[d], gt[d], nb[d]}), int'({l0, e0, g0, n0}));
    end
    ordy[d] = 1'b1;
    @(posedge clk); #1;
    ordy[d] = 1'b0;
    iv[d] = 1'b0;
    chk({tag, ".post_valid"}, int'(ov[d]), 0);
    chk({tag, ".post_ready"}, int'(irdy[d]), 1);
    chk({tag, ".post_out"},   int'({lt[d], eq[d], gt[d], nb[d]}), 0);
  endtask

  initial begin
    int seen_valid;
    logic [7:0] ra, rb;
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      iv[d] = 1'b0; av[d] = '0; bv[d] = '0; sg[d] = 1'b0; ordy[d] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      chk("reset.in_ready",  int'(irdy[d]), 1);
      chk("reset.out_valid", int'(ov[d]), 0);
      chk("reset.outs",      int'({lt[d], eq[d], gt[d], nb[d]}), 0);
    end

    do_op(1, 8'h64, 8'h62, 1'b0, 0, "unsigned_full");
    do_op(0, 8'h5A, 8'h5A, 1'b0, 0, "equal_ee");
    do_op(0, 8'h80, 8'h01, 1'b1, 0, "signed_80_01");
    do_op(0, 8'h80, 8'h01, 1'b0, 0, "unsigned_80_01");
    do_op(1, 8'h80, 8'h01, 1'b1, 0, "signed_full");
    do_op(0, 8'h13, 8'h17, 1'b0, 0, "early_exit");
    do_op(0, 8'h7F, 8'h81, 1'b1, 5, "backpressure");

    // Reset three bits into an operation with equal operands.
    @(negedge clk);
    av[0] = 8'h3C; bv[0] = 8'h3C; sg[0] = 1'b0; iv[0] = 1'b1; ordy[0] = 1'b1;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midreset.in_ready", int'(irdy[0]), 1);
    chk("midreset.out_valid", int'(ov[0]), 0);
    seen_valid = 0;
    for (int i = 0; i < W + 2; i++) begin
      @(posedge clk); #1;
      if (ov[0]) seen_valid = 1;
    end
    chk("midreset.no_result", seen_valid, 0);
    ordy[0] = 1'b0;
    do_op(0, 8'h01, 8'h02, 1'b0, 0, "after_reset");

    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? ra : 8'($urandom);
      do_op(i % 2, ra, rb, 1'($urandom), int'($urandom_range(0, 3)), "random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/serial_compare_sequencer.md
SERIAL_COMPARE_SEQUENCER -- requirements
Module: serial_compare_sequencer

Interface
REQ-001 Parameter: WIDTH, default 8, operand width in bits; legal range 2..32.
REQ-002 Parameter: EARLY_EXIT, default 1; when 1, comparison stops at the first differing bit.
REQ-003 Port: clk  input  1  single clock; all state updates on posedge clk.
REQ-004 Port: rst  input  1  reset, synchronous and active-high.
REQ-005 Port: in_valid  input  1  request present.
REQ-006 Port: in_ready  output  1  block can accept a request.
REQ-007 Port: in_a, in_b  input  WIDTH  operands.
REQ-008 Port: in_signed  input  1  1 = two's-complement compare, 0 = unsigned compare.
REQ-009 Port: out_valid  output  1  result present.
REQ-010 Port: out_ready  input  1  consumer takes the result.
REQ-011 Port: out_less, out_eq, out_greater  output  1 each  result, one-hot while out_valid is high.
REQ-012 Port: out_bits  output  $clog2(WIDTH+1)  number of bits consumed for this result.

Function
REQ-013 FSM states: IDLE, SHIFT, DONE.
REQ-014 IDLE: in_ready=1; on the posedge where in_valid&in_ready is high, the block latches in_a, in_b and in_signed, clears the comparator and bit counter, and goes to SHIFT.
REQ-015 in_ready SHALL be 0 in SHIFT and DONE; in_valid there is ignored and has no side effects.
REQ-016 SHIFT: one bit pair per posedge, MSB first (bit WIDTH-1 down to 0), fed to the comparator core.
REQ-017 Signed mode: the MSB of both operands is inverted before feeding; all other bits pass unchanged.
REQ-018 Comparator core state: EQ until the first bit pair with a!=b, then LESS (a=0,b=1) or GREATER (a=1,b=0); the state SHALL remain sticky for the rest of the operation.
REQ-019 SHIFT->DONE happens on the posedge that consumes bit 0, or, with EARLY_EXIT=1, on the posedge that consumes the first differing pair.
REQ-020 Latency: out_valid rises k posedges after the accept edge, where k = bits consumed; k = WIDTH when the operands are equal or EARLY_EXIT=0.
REQ-021 DONE: out_valid=1; out_less, out_eq, out_greater and out_bits=k SHALL stay stable until the handshake.
REQ-022 DONE->IDLE on the posedge with out_ready=1; no new request is accepted on that same edge.
REQ-023 Outside DONE: out_valid=0, result flags=0, out_bits=0.
REQ-024 out_ready held high continuously: back-to-back throughput is one result per k+2 cycles.

Reset
REQ-025 rst=1 at a posedge forces IDLE, clears the comparator core, counter and operand registers, and gives in_ready=1, out_valid=0, flags=0, out_bits=0 in the following cycle.
REQ-026 Reset during SHIFT or DONE discards the in-flight operation; no result is emitted.
REQ-027 rst has priority over any simultaneous in_valid or out_ready.

Structure
REQ-028 Shared package serial_cmp_pkg SHALL hold:
- the FSM state enum typedef;
- the comparator state enum {CMP_EQ, CMP_LESS, CMP_GREATER};
- a packed result struct {less, eq, greater}.
REQ-029 Sub-module serial_msb_compare_core: the MSB-first bit-serial comparator with inputs clk, rst, clear, en, a, b and output cmp_state; the sequencer instantiates exactly one.
REQ-030 The operand shift registers and bit counter SHALL live in the sequencer; no combinational path from in_* to out_*.

Verification
REQ-031 Unsigned compare: WIDTH=8, EARLY_EXIT=0, a=0x64, b=0x62, in_signed=0 -> out_valid 8 posedges after accept, out_greater=1, out_bits=8.
REQ-032 Equal operands: EARLY_EXIT=1, a=b=0x5A -> out_eq=1, out_bits=8, latency 8.
REQ-033 Signed vs unsigned: a=0x80, b=0x01 -> in_signed=1 gives out_less=1; in_signed=0 gives out_greater=1 and out_bits=1 with EARLY_EXIT=1.
REQ-034 Early exit: a=0x13, b=0x17, EARLY_EXIT=1 -> out_less=1, out_bits=6, out_valid 6 posedges after accept.
REQ-035 Backpressure: out_ready=0 for 5 cycles in DONE while in_valid=1 -> result stable, in_ready=0, no extra accept; out_ready=1 -> IDLE next cycle.
REQ-036 Reset mid-SHIFT: rst pulsed after 3 bits -> next cycle IDLE with in_ready=1; no out_valid pulse; the following request a=0x01, b=0x02 yields out_less=1.
